// File: rtl/cpu_seq_if.sv
// cpu_seq_if: sequencer-side bundle of the shared d_bus, ALU flags/strobes and memory controls.
interface cpu_seq_if;
  logic [7:0] d_bus;
  logic       c;
  logic       z;
  logic [7:0] instruction;
  logic       ldAcc;
  logic       useAlu;
  logic       dbusSelect;
  logic [4:0] mem_addr;
  logic       mem_oe;
  logic       mem_we;
  logic [4:0] pc;
  logic       halted;
  modport master (
    input  d_bus, c, z,
    output instruction, ldAcc, useAlu, dbusSelect, mem_addr, mem_oe, mem_we, pc, halted
  );
  modport slave (
    output d_bus, c, z,
    input  instruction, ldAcc, useAlu, dbusSelect, mem_addr, mem_oe, mem_we, pc, halted
  );
endinterface

// File: rtl/cpu_seq.sv
// cpu_seq: fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Define CPU_SEQ_SINGLE_STEP_EN to add the step input and a WAIT state between instructions.
module cpu_seq #(
  parameter logic [4:0] RESET_PC = 5'h00
) (
  input logic tclk,
  input logic reset,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input logic step,
`endif
  cpu_seq_if.master bus
);
  typedef enum logic [2:0] {
    FETCH_A, FETCH_B, EXEC_A, EXEC_B, HALT
`ifdef CPU_SEQ_SINGLE_STEP_EN
    , WAIT
`endif
  } state_t;
  state_t state, done;
  logic [7:0] ir;
  logic [4:0] pc, a;
  logic [2:0] op;
  logic alu_op, rd_op, is_ld, is_st, is_jmp, taken, fa, ea, eb;
  assign op = ir[7:5];
  assign a = ir[4:0];
  assign alu_op = ~op[2];
  assign rd_op = alu_op & (op != 3'b011);
  assign is_ld = op == 3'b100;
  assign is_st = op == 3'b101;
  assign is_jmp = op[2] & op[1];
  assign taken = op[0] ? bus.c : bus.z;
  assign fa = state == FETCH_A;
  assign ea = state == EXEC_A;
  assign eb = state == EXEC_B;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  assign done = WAIT;
`else
  assign done = FETCH_A;
`endif
  always_ff @(posedge tclk or posedge reset)
    if (reset) begin
      state <= FETCH_A;
      pc <= RESET_PC;
      ir <= '0;
    end else
      case (state)
        FETCH_A: begin
          ir <= bus.d_bus;
          pc <= pc + 5'd1;
          state <= FETCH_B;
        end
        FETCH_B: state <= (ir == 8'hff) ? HALT : EXEC_A;
        EXEC_A: begin
          if (is_jmp && taken) pc <= a;
          state <= (is_ld || is_jmp) ? done : EXEC_B;
        end
        EXEC_B: state <= done;
`ifdef CPU_SEQ_SINGLE_STEP_EN
        WAIT: if (step) state <= FETCH_A;
`endif
        default: state <= HALT;
      endcase
  // Strobes decode only registered state/IR; reset masks them so an in-flight write dies at once.
  assign bus.mem_oe = ~reset & (fa | ea & (rd_op | is_ld));
  assign bus.useAlu = ~reset & ea & (alu_op | is_st);
  assign bus.ldAcc = ~reset & (ea & is_ld | eb & alu_op);
  assign bus.dbusSelect = ~reset & eb;
  assign bus.mem_we = ~reset & eb & is_st;
  assign bus.mem_addr = (ea & (rd_op | is_ld) | eb & is_st) ? a : pc;
  assign bus.instruction = ir;
  assign bus.pc = pc;
  assign bus.halted = state == HALT;
  a_bus_excl: assert property (@(posedge tclk) disable iff (reset) !(bus.mem_oe && bus.dbusSelect));
endmodule

// File: tb/tb_cpu_seq.sv
// tb_cpu_seq: sequencer with a behavioural ALU/memory; scoreboard of observed bus events.
module tb_cpu_seq;
  logic tclk = 0, reset = 1, load = 0;
  always #5 tclk = ~tclk;
  cpu_seq_if bus();
`ifdef CPU_SEQ_SINGLE_STEP_EN
  localparam int W = 1;
  logic step = 1;
  cpu_seq dut (.tclk(tclk), .reset(reset), .step(step), .bus(bus));
`else
  localparam int W = 0;
  cpu_seq dut (.tclk(tclk), .reset(reset), .bus(bus));
`endif
  localparam logic [2:0] FETCH = 0, READ = 1, UALU = 2, LOAD = 3, WRITE = 4, OTHER = 5;
  typedef struct packed {
    logic [2:0] kind;
    logic [4:0] addr;
    logic [7:0] data;
    logic [4:0] pc;
    int cyc;
  } ev_t;
  logic [7:0] mem [32];
  logic [7:0] img [32];
  logic [7:0] acc = '0, latch = '0;
  logic cf = 0, zf = 0;
  logic [8:0] r;
  logic [4:0] stb;
  ev_t exp_q[$];
  int tests = 0, fails = 0, cyc = 0, overlap = 0;
  function automatic logic [8:0] alu(input logic [2:0] op, input logic [4:0] a, input logic [7:0] x, input logic [7:0] y);
    case (op)
      3'b000: return {1'b0, x} + {1'b0, y};
      3'b001: return {1'b0, x} - {1'b0, y};
      3'b010: return {1'b0, ~(x & y)};
      3'b011: return (a == 5'h1f) ? {x[0], 1'b0, x[7:1]} : {x, 1'b0};
      default: return {1'b0, x};
    endcase
  endfunction
  assign r = alu(bus.instruction[7:5], bus.instruction[4:0], acc, bus.d_bus);
  assign bus.d_bus = bus.mem_oe ? mem[bus.mem_addr] : bus.dbusSelect ? latch : 8'h00;
  assign bus.c = cf;
  assign bus.z = zf;
  assign stb = {bus.ldAcc, bus.useAlu, bus.dbusSelect, bus.mem_oe, bus.mem_we};
  always @(posedge tclk) begin
    if (load) for (int i = 0; i < 32; i++) mem[i] <= img[i];
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.d_bus;
    if (bus.ldAcc) acc <= bus.d_bus;
    if (bus.useAlu) begin
      latch <= r[7:0];
      if (bus.instruction[7:5] != 3'b101) begin
        cf <= r[8];
        zf <= r[7:0] == 8'h00;
      end
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic ex(input logic [2:0] k, input logic [4:0] a, input logic [7:0] d, input logic [4:0] p, input int c, input int n);
    exp_q.push_back(ev_t'{k, a, d, p, c + n * W});
  endtask
  task automatic clear_img();
    for (int i = 0; i < 32; i++) img[i] = 8'h00;
  endtask
  task automatic start();
    reset = 1;
    load = 1;
    repeat (2) @(posedge tclk);
    #1 load = 0;
  endtask
  task automatic go();
    @(posedge tclk);
    #1 reset = 0;
  endtask
  task automatic wait_empty(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge tclk);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask
  initial begin
    ev_t e, x;
    logic seen;
    forever begin
      @(negedge tclk);
      if (reset) cyc = 0;
      else begin
        cyc++;
        if (bus.mem_oe && bus.dbusSelect) overlap++;
        seen = 1;
        e = '0;
        if (bus.mem_we) e = ev_t'{WRITE, bus.mem_addr, bus.d_bus, bus.pc, cyc};
        else if (bus.ldAcc) e = ev_t'{LOAD, 5'h00, bus.d_bus, bus.pc, cyc};
        else if (bus.mem_oe && bus.useAlu) e = ev_t'{READ, bus.mem_addr, bus.d_bus, bus.pc, cyc};
        else if (bus.useAlu) e = ev_t'{UALU, 5'h00, 8'h00, bus.pc, cyc};
        else if (bus.mem_oe) e = ev_t'{FETCH, bus.mem_addr, bus.d_bus, bus.pc, cyc};
        else if (bus.dbusSelect) e = ev_t'{OTHER, 5'h00, 8'h00, bus.pc, cyc};
        else seen = 0;
        if (seen) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected event: kind=%0d addr=%h data=%h pc=%h cyc=%0d", e.kind, e.addr, e.data, e.pc, e.cyc);
          end else begin
            x = exp_q.pop_front();
            if (e !== x) begin
              fails++;
              $display("FAIL event: got kind=%0d addr=%h data=%h pc=%h cyc=%0d, expected kind=%0d addr=%h data=%h pc=%h cyc=%0d",
                       e.kind, e.addr, e.data, e.pc, e.cyc, x.kind, x.addr, x.data, x.pc, x.cyc);
            end
          end
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int bad;
    clear_img();
    img[0] = 8'h85;
    img[1] = 8'hff;
    img[5] = 8'h2a;
    start();
    check("rst_strobes", stb, 5'b0);
    check("rst_mem_addr", bus.mem_addr, 5'h00);
    check("rst_pc", bus.pc, 5'h00);
    check("rst_ir", bus.instruction, 8'h00);
    check("rst_halted", bus.halted, 1'b0);
    ex(FETCH, 5'h00, 8'h85, 5'h00, 1, 0);
    ex(LOAD, 5'h00, 8'h2a, 5'h01, 3, 0);
    ex(FETCH, 5'h01, 8'hff, 5'h01, 4, 1);
    go();
    wait_empty("ld_drain");
    check("ld_acc", acc, 8'h2a);
    @(negedge tclk);
    check("halt_decode_cycle", bus.halted, 1'b0);
    @(negedge tclk);
    check("halt_entered", bus.halted, 1'b1);
    bad = 0;
    repeat (20) begin
      @(negedge tclk);
      if (stb !== 5'b0 || bus.halted !== 1'b1) bad++;
    end
    check("halt_hold", bad, 0);
    check("halt_pc", bus.pc, 5'h02);
    #1 reset = 1;
    #1 check("halt_rst_pc", bus.pc, 5'h00);
    check("halt_rst_halted", bus.halted, 1'b0);
    clear_img();
    img[5'h00] = 8'h98; img[5'h01] = 8'h06; img[5'h02] = 8'h99; img[5'h03] = 8'ha7;
    img[5'h04] = 8'h1a; img[5'h05] = 8'hca; img[5'h06] = 8'h20; img[5'h0a] = 8'h1b;
    img[5'h0b] = 8'hea; img[5'h0c] = 8'h9d; img[5'h0d] = 8'h1d; img[5'h0e] = 8'hdf;
    img[5'h18] = 8'hf0; img[5'h19] = 8'h3c; img[5'h1a] = 8'hc4; img[5'h1b] = 8'h01;
    img[5'h1d] = 8'h00; img[5'h1f] = 8'hea;
    start();
    ex(FETCH, 5'h00, 8'h98, 5'h00, 1, 0);
    ex(LOAD, 5'h00, 8'hf0, 5'h01, 3, 0);
    ex(FETCH, 5'h01, 8'h06, 5'h01, 4, 1);
    ex(READ, 5'h06, 8'h20, 5'h02, 6, 1);
    ex(LOAD, 5'h00, 8'h10, 5'h02, 7, 1);
    ex(FETCH, 5'h02, 8'h99, 5'h02, 8, 2);
    ex(LOAD, 5'h00, 8'h3c, 5'h03, 10, 2);
    ex(FETCH, 5'h03, 8'ha7, 5'h03, 11, 3);
    ex(UALU, 5'h00, 8'h00, 5'h04, 13, 3);
    ex(WRITE, 5'h07, 8'h3c, 5'h04, 14, 3);
    ex(FETCH, 5'h04, 8'h1a, 5'h04, 15, 4);
    ex(READ, 5'h1a, 8'hc4, 5'h05, 17, 4);
    ex(LOAD, 5'h00, 8'h00, 5'h05, 18, 4);
    ex(FETCH, 5'h05, 8'hca, 5'h05, 19, 5);
    ex(FETCH, 5'h0a, 8'h1b, 5'h0a, 22, 6);
    ex(READ, 5'h1b, 8'h01, 5'h0b, 24, 6);
    ex(LOAD, 5'h00, 8'h01, 5'h0b, 25, 6);
    ex(FETCH, 5'h0b, 8'hea, 5'h0b, 26, 7);
    ex(FETCH, 5'h0c, 8'h9d, 5'h0c, 29, 8);
    ex(LOAD, 5'h00, 8'h00, 5'h0d, 31, 8);
    ex(FETCH, 5'h0d, 8'h1d, 5'h0d, 32, 9);
    ex(READ, 5'h1d, 8'h00, 5'h0e, 34, 9);
    ex(LOAD, 5'h00, 8'h00, 5'h0e, 35, 9);
    ex(FETCH, 5'h0e, 8'hdf, 5'h0e, 36, 10);
    ex(FETCH, 5'h1f, 8'hea, 5'h1f, 39, 11);
    ex(FETCH, 5'h00, 8'h98, 5'h00, 42, 12);
    go();
    wait_empty("prog_drain");
    check("st_mem7", mem[7], 8'h3c);
    #1 reset = 1;
    clear_img();
    img[0] = 8'ha7;
    img[7] = 8'h55;
    start();
    ex(FETCH, 5'h00, 8'ha7, 5'h00, 1, 0);
    ex(UALU, 5'h00, 8'h00, 5'h01, 3, 0);
    go();
    repeat (3) @(negedge tclk);
    #1 check("stA_useAlu", bus.useAlu, 1'b1);
    reset = 1;
    #1 check("stA_rst_strobes", stb, 5'b0);
    repeat (2) @(posedge tclk);
    #1 check("stA_no_write", mem[7], 8'h55);
    ex(FETCH, 5'h00, 8'ha7, 5'h00, 1, 0);
    ex(UALU, 5'h00, 8'h00, 5'h01, 3, 0);
    go();
    repeat (3) @(negedge tclk);
    @(posedge tclk);
    #1 check("stB_we", bus.mem_we, 1'b1);
    reset = 1;
    #1 check("stB_we_async_drop", bus.mem_we, 1'b0);
    @(posedge tclk);
    #1 check("stB_no_write", mem[7], 8'h55);
    check("restart_drain", exp_q.size(), 0);
    check("bus_overlap", overlap, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
